// File: rtl/reset_cmd_master_if.sv
// Command/response and pipelined Wishbone signal bundle for reset_cmd_master.
// Suffixes are from the master's point of view.
interface reset_cmd_master_if;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CDAT_W = 3;
  localparam int unsigned RSP_W  = 6;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned SEL_W  = 4;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [OP_W-1:0]   cmd_op_i;
  logic [CDAT_W-1:0] cmd_data_i;
  logic              rsp_valid_o;
  logic [RSP_W-1:0]  rsp_data_o;
  logic              rsp_err_o;
  logic              wb_adr_o;
  logic [DAT_W-1:0]  wb_dat_w_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic              wb_we_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [DAT_W-1:0]  wb_dat_r_i;
  logic              wb_stall_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output wb_adr_o, wb_dat_w_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_r_i, wb_stall_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  wb_adr_o, wb_dat_w_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_r_i, wb_stall_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/reset_cmd_master.sv
// Turns reset-strobe / reset-reason commands into single pipelined Wishbone
// transactions with stall handling, ack/err completion and a response timeout.
module reset_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  reset_cmd_master_if.master  bus
);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned RSP_W  = 6;
  localparam int unsigned CDAT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_e;

  state_e             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic               adr_q, adr_d;
  logic [DAT_W-1:0]   dat_w_q, dat_w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [RSP_W-1:0]   rsp_data_q, rsp_data_d;
  logic               done_c;
  logic               done_err_c;
  logic               unused_c;

  assign unused_c = ^bus.wb_dat_r_i[DAT_W-1:RSP_W];

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 1'b0;
      dat_w_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_w_q     <= dat_w_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_w_d     = dat_w_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    done_c      = 1'b0;
    done_err_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          if (bus.cmd_op_i == 2'b11) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = (bus.cmd_op_i == 2'b00);
            adr_d   = (bus.cmd_op_i == 2'b01);
            dat_w_d = (bus.cmd_op_i == 2'b00) ? DAT_W'(bus.cmd_data_i) : '0;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        // Completion is only honoured once the strobe has been accepted.
        if (!bus.wb_stall_i) begin
          stb_d = 1'b0;
          if (bus.wb_ack_i || bus.wb_err_i) begin
            done_c     = 1'b1;
            done_err_c = bus.wb_err_i;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (bus.wb_ack_i || bus.wb_err_i) begin
          done_c     = 1'b1;
          done_err_c = bus.wb_err_i;
        end else if (cnt_q == CNT_LAST) begin
          done_c     = 1'b1;
          done_err_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Close the bus cycle and launch the single response pulse.
    if (done_c) begin
      state_d     = S_RSP;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      we_d        = 1'b0;
      adr_d       = 1'b0;
      dat_w_d     = '0;
      cnt_d       = '0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = done_err_c;
      rsp_data_d  = (!we_q && !done_err_c) ? bus.wb_dat_r_i[RSP_W-1:0] : '0;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = stb_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_w_o  = dat_w_q;
  assign bus.wb_sel_o    = 4'hF;

  localparam int unsigned CDAT_UNUSED = CDAT_W;
endmodule

// File: doc/reset_cmd_master.md
RESET_CMD_MASTER -- requirements
Module: reset_cmd_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of cycles to wait for ack/err after strobe acceptance before abort (range 2..255).
REQ-002 sys_clk  in  1  system clock; all logic in this single domain.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid_i  in  1  command request.
REQ-005 cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-006 cmd_op_i  in  2  00 = write reset strobes, 01 = read-and-clear reset reason, 10 = peek reset reason, 11 = illegal.
REQ-007 cmd_data_i  in  3  reset strobe bits for op 00: [0] ndm, [1] dm, [2] usb.
REQ-008 rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
REQ-009 rsp_data_o  out  6  reset reason bits from read data [5:0].
REQ-010 rsp_err_o  out  1  qualifies rsp_valid_o: bus error, timeout, or illegal op.
REQ-011 wb_adr_o  out  1; wb_dat_w_o  out  32; wb_sel_o  out  4; wb_we_o  out  1; wb_cyc_o  out  1; wb_stb_o  out  1: pipelined Wishbone initiator outputs.
REQ-012 wb_dat_r_i  in  32; wb_stall_i  in  1; wb_ack_i  in  1; wb_err_i  in  1: Wishbone responder returns.

Function
REQ-013 FSM states IDLE, REQ, WAIT, RSP; cmd_ready_o SHALL be 1 only in IDLE.
REQ-014 IDLE: on accepted op 00/01/10 SHALL register op/data, drive cyc=stb=1, go REQ; on op 11 SHALL go RSP with rsp_err_o=1, no bus cycle.
REQ-015 Op 00: wb_we_o=1, wb_adr_o=0, wb_dat_w_o={29'b0, cmd_data_i}.
REQ-016 Op 01: wb_we_o=0, wb_adr_o=1 (responder clears reason on ack); op 10: wb_we_o=0, wb_adr_o=0.
REQ-017 wb_sel_o SHALL be 4'hF for all ops; wb_dat_w_o SHALL be 0 for reads.
REQ-018 REQ: stb held with stable adr/we/dat until a cycle with wb_stall_i=0; that cycle is acceptance; stb drops next cycle.
REQ-019 Ack/err in the acceptance cycle or any later cycle with cyc high SHALL end the cycle: cyc drops next edge, go RSP; ack/err while stalled before acceptance SHALL be ignored.
REQ-020 WAIT: cyc=1, stb=0, counter increments per cycle from 0 at acceptance; at counter == TIMEOUT_CYCLES-1 without ack/err SHALL drop cyc and go RSP with rsp_err_o=1.
REQ-021 Ack and err in the same cycle: err wins, rsp_err_o=1.
REQ-022 RSP: rsp_valid_o=1 for exactly one cycle, then IDLE; rsp_data_o = wb_dat_r_i[5:0] captured on ack for reads, 0 for writes, errors and timeouts.
REQ-023 Command-to-cmd_ready_o latency, zero stall, ack in acceptance cycle: 3 cycles (REQ, RSP, IDLE).
REQ-024 Stall and timeout counting SHALL be independent: stall does not time out.
REQ-025 Counter width 8 bits; no wrap in normal operation (abort precedes overflow).

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, cyc=stb=we=0, adr=0, dat_w=0, rsp_valid=rsp_err=0, rsp_data=0, counter=0, cmd_ready_o=1 after release.
REQ-027 Reset mid-transaction SHALL drop cyc/stb at that edge with no response pulse; late ack after reset SHALL be ignored.

Verification
REQ-028 Op 00, data 3'b101, stall=0, ack in acceptance cycle -> one write, adr=0, dat_w=32'h5, sel=F; rsp_valid 1 cycle, err=0, data=0.
REQ-029 Op 01, stall=1 for 3 cycles, ack 2 cycles after acceptance with dat_r=32'h12 -> stb high 4 cycles, adr=1, we=0; rsp_data=6'h12, err=0.
REQ-030 Op 10, responder never acks, TIMEOUT_CYCLES=4 -> cyc drops 4 cycles after acceptance; rsp_valid with err=1, data=0.
REQ-031 Op 00, ack and err same cycle -> rsp_err=1; op 11 -> no cyc, rsp_valid with err=1 next cycle.
REQ-032 rst_n=0 while in WAIT, then ack -> cyc=0 at reset edge, no rsp_valid, cmd_ready=1 after release.
REQ-033 Back-to-back: cmd_valid held with two ops -> second accepted only after first rsp_valid; no overlapping cyc.
